uart_text_console: RTL and testbench

Console front end between the UART receiver and the text-to-VRAM character writer. It buffers received bytes in a small FIFO and interprets control codes (CR, LF, BS). It tracks the text cursor and issues one `write_char` request at a time, waiting for the writer's `char_done` before advancing. This replaces ad-hoc per-byte edge detection, so bytes arriving while the writer is busy are no longer lost.

---
 rtl/uart_text_console_if.sv | 25 ++
 rtl/uart_text_console.sv | 133 +++++++++++++
 tb/tb_uart_text_console.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_text_console_if.sv
// Console bus: UART byte input, character-writer request/response, FIFO status.
// master = the console, slave = its environment (UART receiver + character writer).
interface uart_text_console_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [6:0]  ascii_out;
   logic [11:0] color_out;
   logic [6:0]  text_x;
   logic [4:0]  text_y;
   logic        write_char;
   logic        char_busy;
   logic        char_done;
   logic        fifo_full;
   logic        overflow;

   modport master (
      input  rx_data, rx_valid, char_busy, char_done,
      output ascii_out, color_out, text_x, text_y, write_char, fifo_full, overflow
   );

   modport slave (
      output rx_data, rx_valid, char_busy, char_done,
      input  ascii_out, color_out, text_x, text_y, write_char, fifo_full, overflow
   );
endinterface

// File: rtl/uart_text_console.sv
// Text console front end: buffers UART bytes, decodes CR/LF/BS, tracks the cursor and
// issues one character write at a time to the VRAM writer.
module uart_text_console #(
   parameter int unsigned TEXT_COLS     = 106,
   parameter int unsigned TEXT_ROWS     = 30,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter logic [11:0] DEFAULT_COLOR = 12'hFFF
) (
   input logic                 clk,
   input logic                 rst,
   uart_text_console_if.master bus
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StDecode, StIssue, StWait} state_e;

   state_e          r_state, w_state_next;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_cur_byte;
   logic [6:0]      r_cursor_x, r_text_x, r_ascii;
   logic [4:0]      r_cursor_y, r_text_y;
   logic            r_erase;

   logic            w_full, w_empty, w_push, w_pop;
   logic            w_printable, w_bs_erase;
   logic [4:0]      w_y_inc;

   // Full uses the pre-cycle count, so a push on a full FIFO drops even with a pop.
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = bus.rx_valid && !w_full;
   assign w_printable = (r_cur_byte >= 8'h20) && (r_cur_byte <= 8'h7E);
   assign w_bs_erase  = (r_cur_byte == 8'h08) && (r_cursor_x != '0);
   assign w_y_inc     = (r_cursor_y == 5'(TEXT_ROWS - 1)) ? 5'd0 : r_cursor_y + 5'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (!w_empty) w_state_next = StDecode;
         StDecode: w_state_next = (w_printable || w_bs_erase) ? StIssue : StIdle;
         StIssue:  w_state_next = StWait;
         StWait:   if (bus.char_done) w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_pop          = (r_state == StIdle) && !w_empty;
      bus.write_char = (r_state == StIssue);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur_byte <= '0;
         r_cursor_x <= '0;
         r_cursor_y <= '0;
         r_text_x   <= '0;
         r_text_y   <= '0;
         r_ascii    <= '0;
         r_erase    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: if (w_pop) r_cur_byte <= r_mem[r_rd_ptr];
            StDecode: begin
               if (r_cur_byte == 8'h0D) begin
                  r_cursor_x <= '0;
               end else if (r_cur_byte == 8'h0A) begin
                  r_cursor_y <= w_y_inc;
               end else if (w_bs_erase) begin
                  r_cursor_x <= r_cursor_x - 7'd1;
                  r_text_x   <= r_cursor_x - 7'd1;
                  r_text_y   <= r_cursor_y;
                  r_ascii    <= 7'h20;
                  r_erase    <= 1'b1;
               end else if (w_printable) begin
                  r_text_x   <= r_cursor_x;
                  r_text_y   <= r_cursor_y;
                  r_ascii    <= r_cur_byte[6:0];
                  r_erase    <= 1'b0;
               end
            end
            StWait: begin
               // Erase writes leave the cursor on the blanked cell.
               if (bus.char_done && !r_erase) begin
                  if (r_cursor_x < 7'(TEXT_COLS - 1)) begin
                     r_cursor_x <= r_cursor_x + 7'd1;
                  end else begin
                     r_cursor_x <= '0;
                     r_cursor_y <= w_y_inc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ascii_out = r_ascii;
   assign bus.color_out = DEFAULT_COLOR;
   assign bus.text_x    = r_text_x;
   assign bus.text_y    = r_text_y;
   assign bus.fifo_full = w_full;
   assign bus.overflow  = bus.rx_valid && w_full;

endmodule

// File: tb/tb_uart_text_console.sv
// Directed bench for uart_text_console: vector table of single bytes plus
// multi-byte sequences (burst, wrap, FIFO overflow, reset during WAIT).
module tb_uart_text_console;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_text_console_if bus ();

   uart_text_console #(
      .TEXT_COLS     (106),
      .TEXT_ROWS     (30),
      .FIFO_DEPTH    (16),
      .DEFAULT_COLOR (12'hFFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [7:0] b;
      bit         wr;
      int         asc;
      int         x;
      int         y;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;
   int g_cyc = 0;
   int g_lat = 0;
   int g_cd = 0;
   int g_push_cyc = 0;
   int q_asc[$];
   int q_x[$];
   int q_y[$];
   int q_cyc[$];
   bit q_ovf[$];
   logic [7:0] tx_q[$];
   vec_t vecs[16];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // One cycle: writer model answers with char_done g_lat cycles after each write_char.
   task automatic tick();
      @(negedge clk);
      g_cyc++;
      bus.char_done = 1'b0;
      if (g_cd > 0) begin
         g_cd--;
         if (g_cd == 0) bus.char_done = 1'b1;
      end
      if (bus.write_char) begin
         q_asc.push_back(int'(bus.ascii_out));
         q_x.push_back(int'(bus.text_x));
         q_y.push_back(int'(bus.text_y));
         q_cyc.push_back(g_cyc);
         if (g_lat > 0) g_cd = g_lat;
      end
   endtask

   task automatic clear_q();
      q_asc.delete(); q_x.delete(); q_y.delete(); q_cyc.delete(); q_ovf.delete();
   endtask

   task automatic push_burst();
      for (int i = 0; i < tx_q.size(); i++) begin
         tick();
         if (i == 0) g_push_cyc = g_cyc;
         bus.rx_data  = tx_q[i];
         bus.rx_valid = 1'b1;
         #1;
         q_ovf.push_back(bus.overflow);
      end
      tick();
      bus.rx_valid = 1'b0;
      tx_q.delete();
   endtask

   task automatic send1(input logic [7:0] b);
      tx_q.push_back(b);
      push_burst();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.char_done = 1'b0;
      bus.rx_valid  = 1'b0;
      g_cd = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_write(input string nm, input int idx, input int a, input int x, input int y);
      if (q_asc.size() > idx) begin
         chk({nm, " ascii"}, q_asc[idx], a);
         chk({nm, " x"}, q_x[idx], x);
         chk({nm, " y"}, q_y[idx], y);
      end else begin
         chk({nm, " missing write"}, q_asc.size(), idx + 1);
      end
   endtask

   initial begin
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.char_busy = 1'b0;
      bus.char_done = 1'b0;

      vecs[0]  = '{8'h41, 1'b1, 'h41, 0, 0};
      vecs[1]  = '{8'h42, 1'b1, 'h42, 1, 0};
      vecs[2]  = '{8'h0D, 1'b0, 0, 0, 0};
      vecs[3]  = '{8'h0A, 1'b0, 0, 0, 0};
      vecs[4]  = '{8'h43, 1'b1, 'h43, 0, 1};
      vecs[5]  = '{8'h08, 1'b1, 'h20, 0, 1};
      vecs[6]  = '{8'h08, 1'b0, 0, 0, 0};
      vecs[7]  = '{8'h44, 1'b1, 'h44, 0, 1};
      vecs[8]  = '{8'h01, 1'b0, 0, 0, 0};
      vecs[9]  = '{8'h7F, 1'b0, 0, 0, 0};
      vecs[10] = '{8'hC1, 1'b0, 0, 0, 0};
      vecs[11] = '{8'h7E, 1'b1, 'h7E, 1, 1};
      vecs[12] = '{8'h20, 1'b1, 'h20, 2, 1};
      vecs[13] = '{8'h08, 1'b1, 'h20, 2, 1};
      vecs[14] = '{8'h65, 1'b1, 'h65, 2, 1};
      vecs[15] = '{8'h0D, 1'b0, 0, 0, 0};

      do_reset();
      chk("reset write_char", int'(bus.write_char), 0);
      chk("reset overflow", int'(bus.overflow), 0);
      chk("reset fifo_full", int'(bus.fifo_full), 0);
      chk("reset color", int'(bus.color_out), 'hFFF);
      chk("reset ascii", int'(bus.ascii_out), 0);
      chk("reset text_x", int'(bus.text_x), 0);
      chk("reset text_y", int'(bus.text_y), 0);

      // Single bytes, writer answers 5 cycles after each request.
      g_lat = 5;
      for (int v = 0; v < 16; v++) begin
         clear_q();
         send1(vecs[v].b);
         repeat (12) tick();
         chk($sformatf("vec%0d writes", v), q_asc.size(), vecs[v].wr ? 1 : 0);
         if (vecs[v].wr && q_asc.size() == 1) begin
            chk_write($sformatf("vec%0d", v), 0, vecs[v].asc, vecs[v].x, vecs[v].y);
            chk($sformatf("vec%0d latency", v), q_cyc[0] - g_push_cyc, 3);
         end
      end

      // "AB" CR LF "C" back to back, 20-cycle writer.
      do_reset();
      clear_q();
      g_lat = 20;
      tx_q = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h43};
      push_burst();
      repeat (120) tick();
      chk("burst writes", q_asc.size(), 3);
      chk_write("burst A", 0, 'h41, 0, 0);
      chk_write("burst B", 1, 'h42, 1, 0);
      chk_write("burst C", 2, 'h43, 0, 1);

      // Drive cursor to (105,29), then 'Z' and 'Y' wrap to (0,0).
      do_reset();
      g_lat = 1;
      for (int i = 0; i < 29; i++) begin
         send1(8'h0A);
         tick();
      end
      for (int i = 0; i < 105; i++) begin
         send1(8'h2E);
         repeat (8) tick();
      end
      clear_q();
      g_lat = 3;
      tx_q = '{8'h5A, 8'h59};
      push_burst();
      repeat (40) tick();
      chk("wrap writes", q_asc.size(), 2);
      chk_write("wrap Z", 0, 'h5A, 105, 29);
      chk_write("wrap Y", 1, 'h59, 0, 0);

      // Writer stalled: 20 consecutive bytes, only 17 accepted.
      do_reset();
      clear_q();
      g_lat = 0;
      for (int i = 0; i < 20; i++) tx_q.push_back(8'h61 + 8'(i));
      push_burst();
      for (int i = 0; i < 20; i++) chk($sformatf("overflow byte%0d", i), int'(q_ovf[i]), (i >= 17) ? 1 : 0);
      chk("fifo_full stalled", int'(bus.fifo_full), 1);
      g_lat = 2;
      g_cd = 2;
      repeat (160) tick();
      chk("stall writes", q_asc.size(), 17);
      for (int i = 0; i < 17; i++) begin
         if (q_asc.size() > i) begin
            chk($sformatf("stall%0d ascii", i), q_asc[i], 'h61 + i);
            chk($sformatf("stall%0d x", i), q_x[i], i);
         end
      end
      chk("fifo_full drained", int'(bus.fifo_full), 0);

      // Reset while waiting on the writer, then a stray char_done.
      do_reset();
      g_lat = 2;
      send1(8'h41);
      repeat (10) tick();
      clear_q();
      g_lat = 0;
      send1(8'h42);
      repeat (6) tick();
      chk("pre-reset write x", (q_x.size() == 1) ? q_x[0] : -1, 1);
      do_reset();
      chk("midwait reset ascii", int'(bus.ascii_out), 0);
      chk("midwait reset text_x", int'(bus.text_x), 0);
      clear_q();
      @(negedge clk);
      bus.char_done = 1'b1;
      @(negedge clk);
      bus.char_done = 1'b0;
      repeat (10) tick();
      chk("stray done writes", q_asc.size(), 0);
      g_lat = 2;
      send1(8'h4B);
      repeat (10) tick();
      chk("after reset writes", q_asc.size(), 1);
      chk_write("after reset K", 0, 'h4B, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
